kij_sequencer: RTL and testbench

//  Control FSM for the corelet datapath (AW SRAM -> L0 -> mac_array -> ofifo -> PMEM).
//  Per kernel position kij: loads ROW weight words into L0 and shifts them into the array.

---
 rtl/corelet_pkg.sv | 35 +++
 rtl/aw_addr_gen.sv | 36 +++
 rtl/kij_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_kij_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/corelet_pkg.sv
// corelet_pkg: sequencer state, array instruction
// codes and default corelet geometry.
package corelet_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_LOAD,
    W_SHIFT,
    A_LOAD,
    A_EXEC,
    DRAIN,
    CLEAR,
    DONE
  } seq_state_t;

  localparam logic [1:0] INST_IDLE  = 2'b00;
  localparam logic [1:0] INST_KLOAD = 2'b01;
  localparam logic [1:0] INST_EXEC  = 2'b10;

  localparam int DEF_ROW    = 8;
  localparam int DEF_COL    = 8;
  localparam int DEF_NKIJ   = 9;
  localparam int DEF_NACT   = 36;
  localparam int DEF_A_BASE = 72;

  function automatic int cnt_span(
    input int row,
    input int kflush,
    input int nact
  );
    return (nact + 1 > row + kflush) ?
      nact + 1 : row + kflush;
  endfunction

endpackage

// File: rtl/aw_addr_gen.sv
// aw_addr_gen: AW SRAM address and chip enable
// for weight and activation fetch phases.
module aw_addr_gen
  import corelet_pkg::*;
#(
  parameter int ROW    = DEF_ROW,
  parameter int NACT   = DEF_NACT,
  parameter int A_BASE = DEF_A_BASE,
  parameter int AW_AW  = 7,
  parameter int CW     = 6
) (
  input  seq_state_t       state,
  input  logic [3:0]       kij,
  input  logic [CW-1:0]    cnt,
  output logic [AW_AW-1:0] aw_addr,
  output logic             aw_cen_n
);

  always_comb begin
    aw_addr  = '0;
    aw_cen_n = 1'b1;
    unique case (1'b1)
      state == W_LOAD && cnt < CW'(ROW): begin
        aw_cen_n = 1'b0;
        aw_addr  = AW_AW'(int'(kij) * ROW
                   + int'(cnt));
      end
      state == A_LOAD && cnt < CW'(NACT): begin
        aw_cen_n = 1'b0;
        aw_addr  = AW_AW'(A_BASE + int'(cnt));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/kij_sequencer.sv
// kij_sequencer: per-kij weight load, activation
// stream and ofifo drain control for the corelet.
module kij_sequencer
  import corelet_pkg::*;
#(
  parameter int ROW    = DEF_ROW,
  parameter int COL    = DEF_COL,
  parameter int NKIJ   = DEF_NKIJ,
  parameter int NACT   = DEF_NACT,
  parameter int A_BASE = DEF_A_BASE,
  parameter int KFLUSH = DEF_ROW + DEF_COL,
  parameter int AW_AW  = 7,
  parameter int OP_AW  = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seq_begin,
  output logic             seq_done,
  output logic             busy,
  output logic [AW_AW-1:0] aw_addr,
  output logic             aw_cen,
  output logic             aw_wen,
  output logic             l0_wr,
  output logic             l0_rd,
  input  logic             l0_full,
  output logic [1:0]       inst_w,
  output logic             weight_clr,
  input  logic             ofifo_valid,
  output logic             ofifo_rd,
  output logic [OP_AW-1:0] op_addr,
  output logic             op_wr,
  output logic             acc_en,
  output logic [3:0]       kij,
  output logic             err
);

  localparam int CW  =
    $clog2(cnt_span(ROW, KFLUSH, NACT) + 1);
  localparam int OCW = $clog2(NACT + 1);

  if (NKIJ < 1 || NKIJ > 16 || ROW < 1 ||
      COL < 1 || NACT < 1 || KFLUSH < 1 ||
      (1 << OP_AW) < NACT) begin : g_bad_param
    $error("kij_sequencer: illegal parameters");
  end

  seq_state_t       state_q, state_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [3:0]       kij_q, kij_n;
  logic [OCW-1:0]   oc_q, oc_n;
  logic             pop;
  logic [1:0]       inst_n;
  logic             l0_rd_n, clr_n;
  logic [AW_AW-1:0] addr_n;
  logic             cen_n;

  // pop is same-cycle with ofifo_valid so
  // back-to-back rows drain one per cycle
  assign pop = ofifo_valid
             && oc_q < OCW'(NACT)
             && (state_q == A_EXEC
              || state_q == DRAIN);

  assign ofifo_rd = pop;
  assign op_wr    = pop;
  assign op_addr  = OP_AW'(oc_q);
  assign kij      = kij_q;
  assign aw_wen   = 1'b1;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q + CW'(1);
    kij_n   = kij_q;
    oc_n    = pop ? oc_q + OCW'(1) : oc_q;
    unique case (state_q)
      IDLE: begin
        cnt_n = '0;
        if (seq_begin) begin
          state_n = W_LOAD;
          kij_n   = '0;
          oc_n    = '0;
        end
      end
      W_LOAD:
        if (cnt_q == CW'(ROW)) begin
          state_n = W_SHIFT;
          cnt_n   = '0;
        end
      W_SHIFT:
        if (cnt_q == CW'(ROW + KFLUSH - 1)) begin
          state_n = A_LOAD;
          cnt_n   = '0;
        end
      A_LOAD:
        if (cnt_q == CW'(NACT)) begin
          state_n = A_EXEC;
          cnt_n   = '0;
        end
      A_EXEC:
        if (cnt_q == CW'(NACT - 1)) begin
          state_n = DRAIN;
          cnt_n   = '0;
        end
      DRAIN: begin
        cnt_n = '0;
        if (oc_q == OCW'(NACT))
          state_n = CLEAR;
      end
      CLEAR: begin
        cnt_n = '0;
        if (kij_q == 4'(NKIJ - 1)) begin
          state_n = DONE;
        end else begin
          state_n = W_LOAD;
          kij_n   = kij_q + 4'd1;
          oc_n    = '0;
        end
      end
      DONE: begin
        cnt_n   = '0;
        state_n = IDLE;
        kij_n   = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    inst_n  = INST_IDLE;
    l0_rd_n = 1'b0;
    clr_n   = 1'b0;
    unique case (1'b1)
      state_n == W_SHIFT
        && cnt_n < CW'(ROW): begin
        inst_n  = INST_KLOAD;
        l0_rd_n = 1'b1;
      end
      state_n == A_EXEC: begin
        inst_n  = INST_EXEC;
        l0_rd_n = 1'b1;
      end
      state_n == CLEAR: clr_n = 1'b1;
      default: ;
    endcase
  end

  aw_addr_gen #(
    .ROW    (ROW),
    .NACT   (NACT),
    .A_BASE (A_BASE),
    .AW_AW  (AW_AW),
    .CW     (CW)
  ) u_addr (
    .state    (state_n),
    .kij      (kij_n),
    .cnt      (cnt_n),
    .aw_addr  (addr_n),
    .aw_cen_n (cen_n)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      kij_q      <= '0;
      oc_q       <= '0;
      aw_addr    <= '0;
      aw_cen     <= 1'b1;
      l0_wr      <= 1'b0;
      l0_rd      <= 1'b0;
      inst_w     <= INST_IDLE;
      weight_clr <= 1'b0;
      seq_done   <= 1'b0;
      busy       <= 1'b0;
      acc_en     <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      kij_q      <= kij_n;
      oc_q       <= oc_n;
      aw_addr    <= addr_n;
      aw_cen     <= cen_n;
      l0_wr      <= ~aw_cen;
      l0_rd      <= l0_rd_n;
      inst_w     <= inst_n;
      weight_clr <= clr_n;
      seq_done   <= state_n == DONE;
      busy       <= state_n != IDLE;
      acc_en     <= kij_n != 4'd0;
      err        <= err | (l0_wr & l0_full);
    end
  end

endmodule

// File: tb/tb_kij_sequencer.sv
// tb_kij_sequencer: table vectors plus random full
// runs against a cycle-offset schedule model.
`timescale 1ns/1ps
module tb_kij_sequencer;

  localparam int ROW    = 8;
  localparam int COL    = 8;
  localparam int NKIJ   = 9;
  localparam int NACT   = 36;
  localparam int A_BASE = 72;
  localparam int KFLUSH = 16;
  localparam int AW_AW  = 7;
  localparam int OP_AW  = 9;
  // block offsets of activation fetch and execute
  localparam int WA = 2 * ROW + 1 + KFLUSH;
  localparam int WE = WA + NACT + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic seq_begin = 1'b0;
  logic l0_full = 1'b0;
  logic ofifo_valid = 1'b0;
  logic seq_done, busy, aw_cen, aw_wen;
  logic l0_wr, l0_rd, weight_clr, ofifo_rd;
  logic op_wr, acc_en, err;
  logic [AW_AW-1:0] aw_addr;
  logic [1:0]       inst_w;
  logic [OP_AW-1:0] op_addr;
  logic [3:0]       kij;

  always #5 clk = ~clk;

  kij_sequencer #(
    .ROW (ROW), .COL (COL), .NKIJ (NKIJ),
    .NACT (NACT), .A_BASE (A_BASE),
    .KFLUSH (KFLUSH), .AW_AW (AW_AW),
    .OP_AW (OP_AW)
  ) dut (
    .clk (clk), .reset (reset),
    .seq_begin (seq_begin), .seq_done (seq_done),
    .busy (busy), .aw_addr (aw_addr),
    .aw_cen (aw_cen), .aw_wen (aw_wen),
    .l0_wr (l0_wr), .l0_rd (l0_rd),
    .l0_full (l0_full), .inst_w (inst_w),
    .weight_clr (weight_clr),
    .ofifo_valid (ofifo_valid),
    .ofifo_rd (ofifo_rd), .op_addr (op_addr),
    .op_wr (op_wr), .acc_en (acc_en),
    .kij (kij), .err (err)
  );

  typedef struct packed {
    logic busy, done, cen, wen, l0w, l0r;
    logic clr, pop, opw, acc, err;
    logic [1:0] inst;
    logic [3:0] kij;
  } ctl_t;

  typedef struct {
    logic sb;
    ctl_t exp;
    int   addr;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  bit   err_m  = 1'b0;
  vec_t tbl [16];

  function automatic ctl_t act();
    return {busy, seq_done, aw_cen, aw_wen,
            l0_wr, l0_rd, weight_clr, ofifo_rd,
            op_wr, acc_en, err, inst_w, kij};
  endfunction

  function automatic ctl_t idle_exp(input logic e);
    ctl_t c;
    c     = '0;
    c.cen = 1'b1;
    c.wen = 1'b1;
    c.err = e;
    return c;
  endfunction

  function automatic ctl_t mk(
    input logic b, input logic c, input logic w,
    input logic r, input logic [1:0] i
  );
    ctl_t x;
    x      = idle_exp(1'b0);
    x.busy = b;
    x.cen  = c;
    x.l0w  = w;
    x.l0r  = r;
    x.inst = i;
    return x;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] got,
    input logic [31:0] want
  );
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h",
               nm, $time, got, want);
    end
  endtask

  task automatic hit_reset();
    ofifo_valid = 1'b1;
    reset       = 1'b1;
    #1;
    chk("reset_now", {15'b0, act()},
        {15'b0, idle_exp(1'b0)});
    chk("reset_opaddr", 32'(op_addr), 0);
    repeat (2) @(posedge clk);
    #1;
    reset       = 1'b0;
    ofifo_valid = 1'b0;
    seq_begin   = 1'b0;
    l0_full     = 1'b0;
    err_m       = 1'b0;
  endtask

  task automatic run_seq(
    input int vpct,
    input bit lfull,
    input int abort_k
  );
    int k = 0, b = 0, pops = 0, o = 0;
    int clr = -1, done_at = -1, wc = 0, dn = 0;
    bit fin = 1'b0;
    ctl_t e;
    @(posedge clk);
    #1;
    seq_begin   = 1'b1;
    l0_full     = 1'b0;
    ofifo_valid = $urandom_range(99) < vpct;
    @(negedge clk);
    chk("start_idle", {15'b0, act()},
        {15'b0, idle_exp(err_m)});
    for (int t = 0; t < 6000 && !fin; t++) begin
      @(posedge clk);
      #1;
      o = t - b;
      if (k == abort_k && o == WE + 3) begin
        hit_reset();
        return;
      end
      seq_begin   = t == ROW + 5 || t == WE + 10;
      ofifo_valid = $urandom_range(99) < vpct;
      l0_full     = lfull && k == 0 && o <= ROW;
      @(negedge clk);
      e      = idle_exp(err_m);
      e.busy = 1'b1;
      e.kij  = 4'(k);
      e.acc  = k != 0;
      if (t == done_at) begin
        e.done = 1'b1;
        fin    = 1'b1;
      end else begin
        if (o < ROW) e.cen = 1'b0;
        if (o >= 1 && o <= ROW) e.l0w = 1'b1;
        if (o > ROW && o <= 2 * ROW) begin
          e.l0r  = 1'b1;
          e.inst = 2'b01;
        end
        if (o >= WA && o < WA + NACT) e.cen = 1'b0;
        if (o > WA && o <= WA + NACT) e.l0w = 1'b1;
        if (o >= WE && o < WE + NACT) begin
          e.l0r  = 1'b1;
          e.inst = 2'b10;
        end
        if (t == clr) begin
          e.clr = 1'b1;
        end else if (o >= WE) begin
          e.pop = ofifo_valid && pops < NACT;
          e.opw = e.pop;
          if (o >= WE + NACT && pops == NACT)
            clr = t + 1;
        end
      end
      chk("ctl", {15'b0, act()}, {15'b0, e});
      if (!e.cen)
        chk("aw_addr", 32'(aw_addr),
            (o < ROW) ? (k * ROW + o) % (1 << AW_AW)
                      : A_BASE + o - WA);
      if (e.pop) chk("op_addr", 32'(op_addr), pops);
      wc += int'(weight_clr);
      dn += int'(seq_done);
      if (e.l0w && l0_full) err_m = 1'b1;
      if (e.pop) pops++;
      if (t == clr) begin
        if (k == NKIJ - 1) begin
          done_at = t + 1;
        end else begin
          k++;
          b    = t + 1;
          pops = 0;
        end
      end
    end
    chk("abort_reached", abort_k, -1);
    chk("seq_finished", 32'(fin), 1);
    chk("wclr_count", wc, NKIJ);
    chk("done_count", dn, 1);
    @(posedge clk);
    #1;
    seq_begin = 1'b0;
    l0_full   = 1'b0;
    @(negedge clk);
    chk("post_done_idle", {15'b0, act()},
        {15'b0, idle_exp(err_m)});
  endtask

  initial begin
    for (int i = 0; i < 5; i++)
      tbl[i] = '{1'b0,
        mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00), 0};
    tbl[5] = '{1'b1,
      mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00), 0};
    tbl[6] = '{1'b0,
      mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00), 0};
    for (int i = 7; i < 14; i++)
      tbl[i] = '{1'b0,
        mk(1'b1, 1'b0, 1'b1, 1'b0, 2'b00), i - 6};
    tbl[14] = '{1'b0,
      mk(1'b1, 1'b1, 1'b1, 1'b0, 2'b00), 0};
    tbl[15] = '{1'b0,
      mk(1'b1, 1'b1, 1'b0, 1'b1, 2'b01), 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {15'b0, act()},
        {15'b0, idle_exp(1'b0)});
    chk("reset_opaddr0", 32'(op_addr), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      seq_begin = tbl[i].sb;
      @(negedge clk);
      chk($sformatf("tbl%0d", i), {15'b0, act()},
          {15'b0, tbl[i].exp});
      if (!tbl[i].exp.cen)
        chk($sformatf("tbl%0d_addr", i),
            32'(aw_addr), tbl[i].addr);
    end

    @(posedge clk);
    #1;
    hit_reset();

    run_seq(100, 1'b0, -1);
    run_seq(50, 1'b0, -1);
    run_seq(50, 1'b0, 4);
    run_seq(70, 1'b1, -1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("err_sticky", 32'(err), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
